axi_lite_master: RTL and testbench

Synthesizable AXI4-Lite master that sits directly upstream of axi_lite_slave and drives its AW/W/B/AR/R channels. It accepts single read or write commands on a simple valid/ready command port and runs exactly one AXI4-Lite transaction per command. It returns the result on a valid/ready response port. The port set matches the slave: no AWPROT/ARPROT, BRESP or RRESP.

---
 rtl/axi_lite_master.sv | 201 ++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: runs one AXI4-Lite read or write per command accepted on
// the cmd_* port and returns the result on the rsp_* port. A sticky watchdog
// flags any single wait phase that lasts TIMEOUT_CYCLES cycles.
module axi_lite_master #(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  // command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response port
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      timeout,
  // write address channel
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  // write data channel
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      WVALID,
  input  logic                      WREADY,
  // write response channel
  input  logic                      BVALID,
  output logic                      BREADY,
  // read address channel
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  // read data channel
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic                      RVALID,
  output logic                      RREADY
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned WD_CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          WD_EN      = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_CNT_W-1:0] WD_LIMIT = WD_CNT_W'(TIMEOUT_CYCLES);
  localparam logic [WD_CNT_W-1:0] WD_LAST  =
    WD_CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t              state;
  logic [WD_CNT_W-1:0] wd_cnt;
  logic                aw_pend;
  logic                w_pend;
  logic                wait_state;
  logic                leaving;

  // Accept commands only while idle and out of reset.
  assign cmd_ready = (state == IDLE) && ARESETn;

  // A write channel is still pending while its VALID is up without READY.
  assign aw_pend = AWVALID && !AWREADY;
  assign w_pend  = WVALID && !WREADY;

  // Flag the watched wait states and the edge on which each one is left.
  always_comb begin
    wait_state = 1'b0;
    leaving    = 1'b0;
    case (state)
      WR_AW_W: begin
        wait_state = 1'b1;
        leaving    = !aw_pend && !w_pend;
      end
      WR_B: begin
        wait_state = 1'b1;
        leaving    = BVALID;
      end
      RD_AR: begin
        wait_state = 1'b1;
        leaving    = ARREADY;
      end
      RD_R: begin
        wait_state = 1'b1;
        leaving    = RVALID;
      end
      default: begin
        wait_state = 1'b0;
        leaving    = 1'b0;
      end
    endcase
  end

  // Transaction FSM with registered channel controls, payloads and response.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= IDLE;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      AWADDR    <= '0;
      WDATA     <= '0;
      WSTRB     <= '0;
      ARADDR    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_write) begin
              AWADDR  <= cmd_addr;
              WDATA   <= cmd_wdata;
              WSTRB   <= STRB_WIDTH'(cmd_wstrb);
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state   <= WR_AW_W;
            end else begin
              ARADDR  <= cmd_addr;
              ARVALID <= 1'b1;
              state   <= RD_AR;
            end
          end
        end
        WR_AW_W: begin
          // Each VALID drops on its own handshake; both may finish together.
          if (AWVALID && AWREADY) AWVALID <= 1'b0;
          if (WVALID && WREADY)   WVALID  <= 1'b0;
          if (!aw_pend && !w_pend) begin
            BREADY <= 1'b1;
            state  <= WR_B;
          end
        end
        WR_B: begin
          if (BVALID) begin
            BREADY    <= 1'b0;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RD_AR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RD_R;
          end
        end
        RD_R: begin
          if (RVALID) begin
            RREADY    <= 1'b0;
            rsp_rdata <= RDATA;
            rsp_write <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Per-phase saturating watchdog; the sticky flag fires on the cycle that
  // completes TIMEOUT_CYCLES cycles in one wait state. The FSM is never aborted.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (wait_state) begin
      if (WD_EN && (wd_cnt == WD_LAST)) timeout <= 1'b1;
      if (leaving) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WD_LIMIT) begin
        wd_cnt <= wd_cnt + WD_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a behavioural AXI4-Lite slave plus a phase-level
// model of the master, compared against the DUT on every falling clock edge.
`timescale 1ns/1ps
module tb_axi_lite_master;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 16;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          timeout;
  logic [AW-1:0] AWADDR;
  logic          AWVALID, AWREADY;
  logic [DW-1:0] WDATA;
  logic [SW-1:0] WSTRB;
  logic          WVALID, WREADY;
  logic          BVALID, BREADY;
  logic [AW-1:0] ARADDR;
  logic          ARVALID, ARREADY;
  logic [DW-1:0] RDATA;
  logic          RVALID, RREADY;

  always #5 ACLK = ~ACLK;

  axi_lite_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .timeout(timeout),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
  );

  // Protocol phase of the current transaction, as seen from the bus.
  typedef enum int {P_IDLE, P_AWW, P_B, P_AR, P_R, P_RSP} phase_e;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  bit     chk_en  = 1'b0;
  bit     rst_req = 1'b1;
  phase_e ph      = P_IDLE;
  bit     aw_done, w_done, exp_to;
  int     wd_cnt;
  logic [DW-1:0] mem [4];

  // transaction in flight
  bit            cur_write;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic [SW-1:0] cur_wstrb;
  logic [DW-1:0] exp_rdata;

  // pending command
  bit            cmd_pend = 1'b0;
  bit            c_w;
  logic [AW-1:0] c_a;
  logic [DW-1:0] c_d;
  logic [SW-1:0] c_s;

  // slave delays: live counters and directed settings
  int  h_aw, h_w, h_b, h_ar, h_r, h_rsp;
  int  d_aw = 0, d_w = 0, d_b = 0, d_ar = 0, d_r = 0, d_rsp = 0;
  bit  rand_mode = 1'b0;
  bit  spur = 1'b0;

  // observations for the literal checks
  int  acc_cyc, awv_cyc, arv_cyc, to_cyc, rspv_cyc;
  int  aw_hi, w_hi, rsp_hi, done_cnt = 0;
  logic [DW-1:0] last_rdata;
  logic          last_rwrite;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input int d);
    return rand_mode ? int'($urandom_range(0, 5)) : d;
  endfunction

  task automatic model_reset();
    ph = P_IDLE; aw_done = 0; w_done = 0; exp_to = 0; wd_cnt = 0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    h_aw = 0; h_w = 0; h_b = 0; h_ar = 0; h_r = 0; h_rsp = 0;
    cmd_pend = 0;
  endtask

  // One clock: compare, drive the slave/command inputs, advance the model.
  task automatic step();
    bit e_aw, e_w;
    @(negedge ACLK);
    cyc++;
    if (chk_en) begin
      check("cmd_ready", 64'(cmd_ready), 64'((ph == P_IDLE) && ARESETn));
      check("awvalid",   64'(AWVALID),   64'(ph == P_AWW && !aw_done));
      check("wvalid",    64'(WVALID),    64'(ph == P_AWW && !w_done));
      check("bready",    64'(BREADY),    64'(ph == P_B));
      check("arvalid",   64'(ARVALID),   64'(ph == P_AR));
      check("rready",    64'(RREADY),    64'(ph == P_R));
      check("rsp_valid", 64'(rsp_valid), 64'(ph == P_RSP));
      check("timeout",   64'(timeout),   64'(exp_to));
      if (ph == P_AWW && !aw_done) check("awaddr", 64'(AWADDR), 64'(cur_addr));
      if (ph == P_AWW && !w_done) begin
        check("wdata", 64'(WDATA), 64'(cur_wdata));
        check("wstrb", 64'(WSTRB), 64'(cur_wstrb));
      end
      if (ph == P_AR) check("araddr", 64'(ARADDR), 64'(cur_addr));
      if (ph == P_RSP) begin
        check("rsp_write", 64'(rsp_write), 64'(cur_write));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      end
      if (AWVALID === 1'b1) aw_hi++;
      if (WVALID === 1'b1) w_hi++;
      if (rsp_valid === 1'b1) rsp_hi++;
      if (AWVALID === 1'b1 && awv_cyc < 0) awv_cyc = cyc;
      if (ARVALID === 1'b1 && arv_cyc < 0) arv_cyc = cyc;
      if (timeout === 1'b1 && to_cyc < 0) to_cyc = cyc;
      if (rsp_valid === 1'b1 && rspv_cyc < 0) rspv_cyc = cyc;
    end

    ARESETn   = !rst_req;
    cmd_valid = cmd_pend;
    cmd_write = c_w; cmd_addr = c_a; cmd_wdata = c_d; cmd_wstrb = c_s;
    AWREADY   = (h_aw == 0);
    WREADY    = (h_w == 0);
    ARREADY   = (h_ar == 0);
    BVALID    = (ph == P_B) ? (h_b == 0) : (spur && $urandom_range(0, 3) == 0);
    RVALID    = (ph == P_R) ? (h_r == 0) : (spur && $urandom_range(0, 3) == 0);
    RDATA     = (ph == P_R) ? mem[cur_addr[3:2]] : DW'($urandom);
    rsp_ready = (ph == P_RSP) ? (h_rsp == 0) : 1'b1;

    if (!ARESETn) begin
      model_reset();
      chk_en = 1'b1;
    end else begin
      if (ph == P_AWW || ph == P_B || ph == P_AR || ph == P_R) begin
        wd_cnt++;
        if (wd_cnt >= int'(TO)) exp_to = 1'b1;
      end
      case (ph)
        P_IDLE: if (cmd_valid) begin
          cur_write = c_w; cur_addr = c_a; cur_wdata = c_d; cur_wstrb = c_s;
          exp_rdata = c_w ? '0 : mem[c_a[3:2]];
          cmd_pend = 0; acc_cyc = cyc;
          awv_cyc = -1; arv_cyc = -1; to_cyc = -1; rspv_cyc = -1;
          aw_hi = 0; w_hi = 0; rsp_hi = 0;
          aw_done = 0; w_done = 0; wd_cnt = 0;
          h_aw = pick(d_aw); h_w = pick(d_w); h_ar = pick(d_ar);
          ph = c_w ? P_AWW : P_AR;
        end
        P_AWW: begin
          e_aw = !aw_done && AWREADY;
          e_w  = !w_done && WREADY;
          if (e_aw) aw_done = 1;
          if (e_w)  w_done = 1;
          if (h_aw > 0) h_aw--;
          if (h_w > 0) h_w--;
          if (aw_done && w_done) begin
            for (int i = 0; i < int'(SW); i++)
              if (cur_wstrb[i]) mem[cur_addr[3:2]][8*i +: 8] = cur_wdata[8*i +: 8];
            ph = P_B; wd_cnt = 0; h_b = pick(d_b);
          end
        end
        P_B:  if (h_b == 0) begin ph = P_RSP; wd_cnt = 0; h_rsp = pick(d_rsp); end else h_b--;
        P_AR: if (h_ar == 0) begin ph = P_R; wd_cnt = 0; h_r = pick(d_r); end else h_ar--;
        P_R:  if (h_r == 0) begin ph = P_RSP; wd_cnt = 0; h_rsp = pick(d_rsp); end else h_r--;
        P_RSP: if (h_rsp == 0) begin
          ph = P_IDLE; done_cnt++;
          last_rdata = rsp_rdata; last_rwrite = rsp_write;
        end else h_rsp--;
        default: ph = P_IDLE;
      endcase
    end
  endtask

  task automatic run_cmd(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    c_w = w; c_a = a; c_d = d; c_s = s; cmd_pend = 1;
    while (done_cnt == start && n < 300) begin
      step();
      n++;
    end
    check("txn_bound", 64'(done_cnt - start), 64'd1);
  endtask

  initial begin
    int n;
    ARESETn = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
    ARREADY = 0; RVALID = 0; RDATA = '0;
    c_w = 0; c_a = '0; c_d = '0; c_s = '0;
    model_reset();

    // reset state
    repeat (3) step();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_awaddr", 64'(AWADDR), 64'd0);
    check("rst_wdata", 64'(WDATA), 64'd0);
    check("rst_araddr", 64'(ARADDR), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    rst_req = 0;
    step();
    #1;
    check("rel_cmd_ready", 64'(cmd_ready), 64'd1);

    // zero-wait write then read back
    run_cmd(1, 4'h4, 32'hDEADBEEF, 4'hF);
    check("wr_valid_lat", 64'(awv_cyc - acc_cyc), 64'd1);
    check("wr_rsp_lat", 64'(rspv_cyc - acc_cyc), 64'd3);
    check("wr_rsp_write", 64'(last_rwrite), 64'd1);
    check("wr_rsp_rdata", 64'(last_rdata), 64'd0);
    run_cmd(0, 4'h4, '0, '0);
    check("rd_valid_lat", 64'(arv_cyc - acc_cyc), 64'd1);
    check("rd_rsp_lat", 64'(rspv_cyc - acc_cyc), 64'd3);
    check("rd_rsp_write", 64'(last_rwrite), 64'd0);
    check("rd_rsp_rdata", 64'(last_rdata), 64'hDEADBEEF);

    // AWREADY stalled 4 cycles, WREADY immediate
    d_aw = 4;
    run_cmd(1, 4'h0, 32'hA5A5_0001, 4'hF);
    d_aw = 0;
    check("stall_aw_hi", 64'(aw_hi), 64'd5);
    check("stall_w_hi", 64'(w_hi), 64'd1);

    // response back-pressure on a write then a read
    d_rsp = 5;
    run_cmd(1, 4'h8, 32'h12345678, 4'h3);
    check("bp_wr_rsp_hi", 64'(rsp_hi), 64'd6);
    run_cmd(0, 4'h8, '0, '0);
    check("bp_rd_rsp_hi", 64'(rsp_hi), 64'd6);
    check("bp_rd_rdata", 64'(last_rdata), 64'h0000_5678);
    d_rsp = 0;

    // all-zero strobes still run a full write that changes nothing
    run_cmd(1, 4'h4, 32'hFFFF_FFFF, 4'h0);
    check("zs_rsp_write", 64'(last_rwrite), 64'd1);
    run_cmd(0, 4'h5, '0, '0);
    check("zs_rdata", 64'(last_rdata), 64'hDEADBEEF);

    // randomized traffic with random slave delays and stray B/R valids
    rand_mode = 1; spur = 1;
    for (int i = 0; i < 60; i++) begin
      n = int'($urandom_range(0, 2));
      repeat (n) step();
      run_cmd(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), SW'($urandom));
    end
    rand_mode = 0; spur = 0;

    // ARREADY held low long enough to trip the watchdog
    d_ar = 25;
    run_cmd(0, 4'hC, '0, '0);
    d_ar = 0;
    check("to_delay", 64'(to_cyc - arv_cyc), 64'd16);
    step();
    check("to_sticky", 64'(timeout), 64'd1);

    // reset for one cycle while waiting in the write-response phase
    d_b = 6;
    c_w = 1; c_a = 4'h8; c_d = 32'hCAFE_F00D; c_s = 4'hF; cmd_pend = 1;
    n = 0;
    while (ph != P_B && n < 20) begin step(); n++; end
    check("reach_wr_b", 64'(ph == P_B), 64'd1);
    step();
    rst_req = 1;
    step();
    rst_req = 0;
    d_b = 0;
    step();
    #1;
    check("mid_awvalid", 64'(AWVALID), 64'd0);
    check("mid_wvalid", 64'(WVALID), 64'd0);
    check("mid_bready", 64'(BREADY), 64'd0);
    check("mid_arvalid", 64'(ARVALID), 64'd0);
    check("mid_rready", 64'(RREADY), 64'd0);
    check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_timeout", 64'(timeout), 64'd0);
    check("mid_cmd_ready", 64'(cmd_ready), 64'd1);
    rsp_hi = 0;
    repeat (5) step();
    check("mid_no_rsp", 64'(rsp_hi), 64'd0);
    run_cmd(0, 4'h8, '0, '0);
    check("mid_rd_after", 64'(last_rdata), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
